// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : regfile_wb_arbiter                                          |
// | Description : Arbitrates the single register-file write port between    |
// |               pipeline writeback and buffered MUL/DIV results, keeps the  |
// |               MUL/DIV pending scoreboard and raises the decode stall.     |
// |               Optional macro WB_FORWARD_EN adds same-cycle forwarding     |
// |               outputs (fwd_rs1_hit, fwd_rs2_hit, fwd_data).               |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module regfile_wb_arbiter #(
  parameter int BUF_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        SYS_reset,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        wb_ready,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  output logic        md_ready,
  input  logic        md_issue,
  input  logic [4:0]  md_issue_rd,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic [4:0]  dec_rd,
  output logic        hazard_stall,
`ifdef WB_FORWARD_EN
  output logic        fwd_rs1_hit,
  output logic        fwd_rs2_hit,
  output logic [31:0] fwd_data,
`endif
  output logic        REG_write_enable,
  output logic [4:0]  REG_write_address,
  output logic [31:0] REG_write_value
);

  localparam int c_PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_SC_W  = $clog2(STARVE_LIMIT + 1);

  logic [4:0]         r_buf_rd   [BUF_DEPTH];
  logic [31:0]        r_buf_data [BUF_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [c_SC_W-1:0]  r_starve_cnt;
  logic               r_force_drain;
  logic [31:0]        r_pending;

  logic               w_empty;
  logic               w_full;
  logic               w_push;
  logic               w_sel_buf;
  logic               w_sel_wb;
  logic [4:0]         w_head_rd;
  logic [31:0]        w_head_data;
  logic [c_SC_W-1:0]  w_starve_nxt;
  logic [31:0]        w_pending_nxt;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == c_CNT_W'(BUF_DEPTH));
  assign w_head_rd   = r_buf_rd[r_rd_ptr];
  assign w_head_data = r_buf_data[r_rd_ptr];

  // A result only enters the buffer when there is room and reset is low.
  assign md_ready = !w_full && !SYS_reset;
  assign w_push   = md_valid && md_ready;

  // Buffer head wins when a drain is forced or the pipeline is idle.
  assign w_sel_buf = !SYS_reset && !w_empty && (r_force_drain || !wb_valid);
  assign w_sel_wb  = !SYS_reset && wb_valid && !(r_force_drain && !w_empty);

  assign wb_ready          = w_sel_wb;
  assign REG_write_enable  = w_sel_buf || w_sel_wb;
  assign REG_write_address = w_sel_buf ? w_head_rd   : wb_rd;
  assign REG_write_value   = w_sel_buf ? w_head_data : wb_data;

  // Scoreboard lookup uses registered state only; gated low during reset.
  assign hazard_stall = !SYS_reset &&
                        (r_pending[dec_rs1] || r_pending[dec_rs2] || r_pending[dec_rd]);

`ifdef WB_FORWARD_EN
  assign fwd_rs1_hit = REG_write_enable && (REG_write_address == dec_rs1) && (dec_rs1 != 5'd0);
  assign fwd_rs2_hit = REG_write_enable && (REG_write_address == dec_rs2) && (dec_rs2 != 5'd0);
  assign fwd_data    = REG_write_value;
`endif

  // Next starvation count and next scoreboard (issue set beats drain clear).
  always_comb begin
    w_starve_nxt  = r_starve_cnt;
    w_pending_nxt = r_pending;
    if (w_sel_buf || w_empty) begin
      w_starve_nxt = '0;
    end else if (w_sel_wb && (r_starve_cnt != c_SC_W'(STARVE_LIMIT))) begin
      w_starve_nxt = r_starve_cnt + c_SC_W'(1);
    end
    if (w_sel_buf) begin
      w_pending_nxt[w_head_rd] = 1'b0;
    end
    if (md_issue && (md_issue_rd != 5'd0)) begin
      w_pending_nxt[md_issue_rd] = 1'b1;
    end
    w_pending_nxt[0] = 1'b0;
  end

  // Buffer storage; contents need no reset since occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_rd[r_wr_ptr]   <= md_rd;
      r_buf_data[r_wr_ptr] <= md_data;
    end
  end

  // Pointers, occupancy, starvation tracking and scoreboard state.
  always_ff @(posedge clk) begin
    if (SYS_reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_starve_cnt  <= '0;
      r_force_drain <= 1'b0;
      r_pending     <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_sel_buf) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_push, w_sel_buf})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_starve_cnt  <= w_starve_nxt;
      r_force_drain <= (w_starve_nxt == c_SC_W'(STARVE_LIMIT));
      r_pending     <= w_pending_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_regfile_wb_arbiter                                       |
// | Description : Self-checking bench for regfile_wb_arbiter: directed       |
// |               scenarios with literal expectations plus a randomized run   |
// |               compared every cycle against a queue-based reference model. |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_regfile_wb_arbiter;

  localparam int BUF_DEPTH    = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        SYS_reset;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_ready;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_ready;
  logic        md_issue;
  logic [4:0]  md_issue_rd;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        hazard_stall;
  logic        REG_write_enable;
  logic [4:0]  REG_write_address;
  logic [31:0] REG_write_value;

  int checks   = 0;
  int failures = 0;

  regfile_wb_arbiter #(
    .BUF_DEPTH    (BUF_DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk               (clk),
    .SYS_reset         (SYS_reset),
    .wb_valid          (wb_valid),
    .wb_rd             (wb_rd),
    .wb_data           (wb_data),
    .wb_ready          (wb_ready),
    .md_valid          (md_valid),
    .md_rd             (md_rd),
    .md_data           (md_data),
    .md_ready          (md_ready),
    .md_issue          (md_issue),
    .md_issue_rd       (md_issue_rd),
    .dec_rs1           (dec_rs1),
    .dec_rs2           (dec_rs2),
    .dec_rd            (dec_rd),
    .hazard_stall      (hazard_stall),
    .REG_write_enable  (REG_write_enable),
    .REG_write_address (REG_write_address),
    .REG_write_value   (REG_write_value)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: result buffer as a queue, scoreboard as a bit array,
  // starvation as a count of consecutive pipeline wins over a waiting result.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] pend;
  int          wins;
  bit          model_on = 0;

  // Compare DUT against model each cycle, then advance model across the edge.
  always @(negedge clk) begin : cmp
    logic        e_md_ready, e_we, e_wbr, e_haz, popped, was_empty, forced;
    logic [4:0]  e_addr;
    logic [31:0] e_val;
    if (SYS_reset) model_on = 1;
    if (model_on) begin
      e_md_ready = !SYS_reset && (mq.size() < BUF_DEPTH);
      forced     = (wins >= STARVE_LIMIT) && (mq.size() > 0);
      e_we = 0; e_wbr = 0; e_addr = 0; e_val = 0; popped = 0;
      if (!SYS_reset) begin
        if (mq.size() > 0 && (forced || !wb_valid)) begin
          e_we = 1; e_addr = mq[0].rd; e_val = mq[0].data; popped = 1;
        end else if (wb_valid) begin
          e_we = 1; e_wbr = 1; e_addr = wb_rd; e_val = wb_data;
        end
      end
      e_haz = !SYS_reset && (pend[dec_rs1] || pend[dec_rs2] || pend[dec_rd]);
      chk("wb_ready", wb_ready, e_wbr);
      chk("md_ready", md_ready, e_md_ready);
      chk("write_enable", REG_write_enable, e_we);
      chk("hazard_stall", hazard_stall, e_haz);
      if (e_we) begin
        chk("write_address", REG_write_address, e_addr);
        chk("write_value", REG_write_value, e_val);
      end
      if (SYS_reset) begin
        mq.delete();
        pend = '0;
        wins = 0;
      end else begin
        was_empty = (mq.size() == 0);
        if (popped) begin
          pend[mq[0].rd] = 1'b0;
          void'(mq.pop_front());
        end
        if (md_valid && e_md_ready) mq.push_back('{rd: md_rd, data: md_data});
        if (popped || was_empty) wins = 0;
        else if (e_wbr && wins < STARVE_LIMIT) wins++;
        if (md_issue && md_issue_rd != 5'd0) pend[md_issue_rd] = 1'b1;
      end
    end
  end

  task automatic settle();
    #3;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid = 0; wb_rd = 0; wb_data = 0;
    md_valid = 0; md_rd = 0; md_data = 0;
    md_issue = 0; md_issue_rd = 0;
    dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
  endtask

  initial begin : stim
    bit acc_wb, acc_md;
    idle_inputs();
    SYS_reset = 1;
    next(); next();

    // Idle out of reset
    SYS_reset = 0;
    settle();
    chk("lit_idle_we", REG_write_enable, 0);
    chk("lit_idle_md_ready", md_ready, 1);
    chk("lit_idle_wb_ready", wb_ready, 0);
    chk("lit_idle_hazard", hazard_stall, 0);
    next();

    // Issue rd=5, stall on it, then result returns
    md_issue = 1; md_issue_rd = 5;
    settle(); next();
    md_issue = 0; dec_rs1 = 5;
    md_valid = 1; md_rd = 5; md_data = 32'h0000_1234;
    settle();
    chk("lit_rs1_stall", hazard_stall, 1);
    next();
    md_valid = 0;
    settle();
    chk("lit_md_we", REG_write_enable, 1);
    chk("lit_md_addr", REG_write_address, 5);
    chk("lit_md_val", REG_write_value, 32'h0000_1234);
    next();
    settle();
    chk("lit_stall_cleared", hazard_stall, 0);
    next();
    idle_inputs();

    // Starvation: buffered rd=7 against continuous pipeline writes
    md_valid = 1; md_rd = 7; md_data = 32'h7777_0007;
    settle(); next();
    md_valid = 0;
    for (int k = 1; k <= 4; k++) begin
      wb_valid = 1; wb_rd = 5'(k + 16); wb_data = 32'(k);
      settle();
      chk("lit_starve_wb_ready", wb_ready, 1);
      chk("lit_starve_wb_addr", REG_write_address, 32'(k + 16));
      next();
    end
    wb_rd = 21; wb_data = 5;
    settle();
    chk("lit_forced_wb_ready", wb_ready, 0);
    chk("lit_forced_addr", REG_write_address, 7);
    chk("lit_forced_val", REG_write_value, 32'h7777_0007);
    next();
    settle();
    chk("lit_after_force_wb_ready", wb_ready, 1);
    chk("lit_after_force_addr", REG_write_address, 21);
    next();
    idle_inputs();

    // Buffer fill with the pipeline busy
    wb_valid = 1;
    md_valid = 1; md_rd = 10; md_data = 32'hA0A0_000A; wb_rd = 1; wb_data = 1;
    settle(); chk("lit_fill1_md_ready", md_ready, 1); next();
    md_rd = 12; md_data = 32'hC0C0_000C; wb_rd = 2; wb_data = 2;
    settle(); chk("lit_fill2_md_ready", md_ready, 1); next();
    md_rd = 13; md_data = 32'hD0D0_000D; wb_rd = 3; wb_data = 3;
    settle(); chk("lit_full_md_ready", md_ready, 0); next();
    wb_rd = 4; wb_data = 4;
    settle(); chk("lit_full2_md_ready", md_ready, 0); next();
    wb_rd = 5; wb_data = 5;
    settle(); chk("lit_full3_wb_ready", wb_ready, 1); next();
    wb_rd = 6; wb_data = 6;
    settle();
    chk("lit_drain_wb_ready", wb_ready, 0);
    chk("lit_drain_addr", REG_write_address, 10);
    chk("lit_drain_md_ready", md_ready, 0);
    next();
    settle();
    chk("lit_third_md_ready", md_ready, 1);
    chk("lit_third_wb_ready", wb_ready, 1);
    next();
    idle_inputs();
    repeat (3) begin settle(); next(); end

    // Set beats clear on rd=9; x0 never pending
    md_valid = 1; md_rd = 9; md_data = 32'h0000_0099;
    settle(); next();
    md_valid = 0; md_issue = 1; md_issue_rd = 9;
    settle();
    chk("lit_rd9_addr", REG_write_address, 9);
    next();
    md_issue = 0; dec_rd = 9;
    settle();
    chk("lit_rd9_still_pending", hazard_stall, 1);
    next();
    dec_rd = 0; md_issue = 1; md_issue_rd = 0;
    settle(); next();
    md_issue = 0;
    settle();
    chk("lit_x0_no_stall", hazard_stall, 0);
    next();

    // Reset with buffered results and pending bits
    md_issue = 1; md_issue_rd = 3; md_valid = 1; md_rd = 3; md_data = 32'h3333;
    wb_valid = 1; wb_rd = 20; wb_data = 32'h20;
    settle(); next();
    md_issue_rd = 4; md_rd = 4; md_data = 32'h4444; wb_rd = 21; wb_data = 32'h21;
    settle(); next();
    md_issue = 0; md_valid = 0; SYS_reset = 1; dec_rs1 = 3;
    settle();
    chk("lit_rst_we", REG_write_enable, 0);
    chk("lit_rst_md_ready", md_ready, 0);
    chk("lit_rst_wb_ready", wb_ready, 0);
    chk("lit_rst_hazard", hazard_stall, 0);
    next();
    SYS_reset = 0; wb_valid = 0; dec_rs2 = 4; dec_rd = 9;
    settle();
    chk("lit_post_rst_we", REG_write_enable, 0);
    chk("lit_post_rst_md_ready", md_ready, 1);
    chk("lit_post_rst_hazard", hazard_stall, 0);
    next();
    idle_inputs();

    // Randomized traffic honouring the hold-until-accepted handshakes
    acc_wb = 1; acc_md = 1;
    for (int i = 0; i < 3000; i++) begin
      SYS_reset = ($urandom_range(0, 199) == 0);
      if (!wb_valid || acc_wb) begin
        wb_valid = ($urandom_range(0, 99) < 60);
        wb_rd    = 5'($urandom_range(0, 31));
        wb_data  = $urandom;
      end
      if (!md_valid || acc_md) begin
        md_valid = ($urandom_range(0, 99) < 35);
        md_rd    = 5'($urandom_range(0, 7));
        md_data  = $urandom;
      end
      md_issue    = ($urandom_range(0, 99) < 30);
      md_issue_rd = 5'($urandom_range(0, 7));
      dec_rs1     = 5'($urandom_range(0, 7));
      dec_rs2     = 5'($urandom_range(0, 7));
      dec_rd      = 5'($urandom_range(0, 7));
      settle();
      acc_wb = wb_valid && wb_ready;
      acc_md = md_valid && md_ready;
      next();
    end

    SYS_reset = 0;
    idle_inputs();
    repeat (4) begin settle(); next(); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
